// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared line/burst geometry and adaptor state encoding
package cache_types_pkg;
   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int BEATS   = LINE_W / BURST_W;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_beat_buffer.sv
// rtl/cacheline_beat_buffer.sv - beat counter, assembled read line and latched write line
module cacheline_beat_buffer #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int CNT_W   = $clog2(LINE_W / BURST_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [LINE_W-1:0]  line_in,
   input  logic               beat,
   input  logic               store,
   input  logic [BURST_W-1:0] burst_in,
   output logic [LINE_W-1:0]  line_out,
   output logic [BURST_W-1:0] burst_out,
   output logic [CNT_W-1:0]   cnt
);
   logic [LINE_W-1:0] wr_line;

   // The counter wraps naturally to 0 on the last beat, ready for the next line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         wr_line  <= '0;
         line_out <= '0;
      end else begin
         if (clear)
            cnt <= '0;
         else if (beat)
            cnt <= cnt + 1'b1;
         if (load)
            wr_line <= line_in;
         if (beat && store)
            line_out[cnt*BURST_W +: BURST_W] <= burst_in;
      end
   end

   assign burst_out = wr_line[cnt*BURST_W +: BURST_W];
endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to 4x64-bit memory burst adaptor
// Optional byte-mask write path enabled by CACHELINE_ADAPTOR_MBE_EN.
module cacheline_adaptor #(
   parameter int LINE_W  = cache_types_pkg::LINE_W,
   parameter int BURST_W = cache_types_pkg::BURST_W,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_MBE_EN
   ,
   input  logic [LINE_W/8-1:0]  mbe_i,
   output logic [BURST_W/8-1:0] burst_mbe_o
`endif
);
   import cache_types_pkg::*;

   localparam int NBEATS = LINE_W / BURST_W;
   localparam int CNT_W  = $clog2(NBEATS);

   adaptor_state_t     state;
   logic [CNT_W-1:0]   beat_cnt;
   logic [BURST_W-1:0] wr_beat;
   logic               accept;
   logic               load_wr;
   logic               beat;
   logic               last;
   logic               unused_addr_bits;

   assign accept  = (state == IDLE) && (read_i || write_i);
   assign load_wr = (state == IDLE) && write_i;
   assign beat    = resp_i && ((state == READ) || (state == WRITE));
   assign last    = (beat_cnt == CNT_W'(NBEATS - 1));
   assign unused_addr_bits = ^address_i[4:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
         address_o <= '0;
      end else begin
         resp_o <= 1'b0;
         case (state)
            IDLE: begin
               if (write_i) begin
                  state     <= WRITE;
                  write_o   <= 1'b1;
                  address_o <= {address_i[ADDR_W-1:5], 5'b0};
               end else if (read_i) begin
                  state     <= READ;
                  read_o    <= 1'b1;
                  address_o <= {address_i[ADDR_W-1:5], 5'b0};
               end
            end
            READ, WRITE: begin
               if (resp_i && last) begin
                  state   <= DONE;
                  read_o  <= 1'b0;
                  write_o <= 1'b0;
                  resp_o  <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   cacheline_beat_buffer #(
      .LINE_W  (LINE_W),
      .BURST_W (BURST_W),
      .CNT_W   (CNT_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept),
      .load      (load_wr),
      .line_in   (line_i),
      .beat      (beat),
      .store     (state == READ),
      .burst_in  (burst_i),
      .line_out  (line_o),
      .burst_out (wr_beat),
      .cnt       (beat_cnt)
   );

   assign burst_o = (state == WRITE) ? wr_beat : '0;

`ifdef CACHELINE_ADAPTOR_MBE_EN
   logic [LINE_W/8-1:0] mbe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mbe_q <= '0;
      else if (load_wr)
         mbe_q <= mbe_i;
   end

   assign burst_mbe_o = (state == WRITE) ? mbe_q[beat_cnt*(BURST_W/8) +: BURST_W/8] : '0;
`endif
endmodule
